operand_loader: RTL and testbench
=================================

# operand_loader

Upstream input stage for the 4-bit add/subtract logic unit. It debounces one active-low pushbutton and steps through a three-press sequence that captures operand A, operand B and the add/subtract select from the board switches. It then holds all three stable and presents them to the add/sub unit with a valid flag. Between presses, switch movement never reaches the datapath.

## Interface
Parameters:
- `W`, 4: operand width; must equal the downstream unit's `2**N`.
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles needed to accept a key level change. The default is 10 ms at 50 MHz. Must be ≥ 2.

Ports:
- `CLOCK_50`  in  1: sole clock; all state changes on rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state immediately.
- `key_n`  in  1: raw pushbutton; asynchronous to `CLOCK_50`; 0 = pressed.
- `sw_data`  in  W: operand switches, sampled only on a capture edge.
- `sw_op`  in  1: 0 = add, 1 = subtract; sampled only on a capture edge.
- `a`  out  W: captured operand A.
- `b`  out  W: captured operand B.
- `op`  out  1: captured select; drives the downstream `S`.
- `valid`  out  1: high while `a`/`b`/`op` form a complete, stable set.
- `start`  out  1: one-cycle pulse on the cycle `valid` rises.
- `stage`  out  2: current FSM state, for LEDs.

## Operation
Debounce:
- 2-flop synchronizer on `key_n` (reset value 1), then a counter feeding a `stable` level (reset value 1).
- If the synchronized value equals `stable`, the counter clears.
- Otherwise the counter increments. When it reaches `DEBOUNCE_CYCLES-1`, `stable` takes the synchronized value and the counter clears.
- `press` is a registered 1-cycle pulse on a 1→0 transition of `stable`. Release produces nothing.
- Counter width: `$clog2(DEBOUNCE_CYCLES)`.

FSM (`stage` encoding in brackets):
- WAIT_A [0]: on `press`, `a <= sw_data`; go to WAIT_B.
- WAIT_B [1]: on `press`, `b <= sw_data`; go to WAIT_OP.
- WAIT_OP [2]: on `press`, `op <= sw_op`, `valid <= 1`, `start <= 1`; go to RUN.
- RUN [3]: hold all outputs. On `press`, `valid <= 0`; go to WAIT_A.
- Without `press`, every state holds.

Register rules:
- `a`, `b` and `op` keep their last values until individually overwritten.
- `valid` is low from the WAIT_A re-entry until the next WAIT_OP capture.
- `start` is high for exactly one cycle per completed sequence.

## Timing
- Reset values: `a`=0, `b`=0, `op`=0, `valid`=0, `start`=0, `stage`=0. Internal: sync flops=1, `stable`=1, counter=0.
- Press latency, numbering the first edge that samples `key_n`=0 as edge 1:
  - synchronized output is 0 after edge 2;
  - `stable` falls on edge `DEBOUNCE_CYCLES+2`;
  - `press` is high after edge `DEBOUNCE_CYCLES+3`;
  - capture and the state change occur on edge `DEBOUNCE_CYCLES+4`.
- Glitches: a low pulse shorter than `DEBOUNCE_CYCLES` synchronized cycles clears the counter and produces no `press`. The same holds for release bounce.
- Held key: exactly one `press`, no matter how long it is held.
- Switch changes on the capture edge itself: the value present at that edge is taken, with no synchronization. Switches are static at human timescales.
- `reset` mid-sequence: the FSM returns to WAIT_A and outputs clear. A key still held when reset deasserts is seen as a new press after the debounce time, because `stable` resets to 1.
- `start` and `valid` rise on the same edge. `valid` falls on the RUN press edge.

## Structure
- Package `loader_pkg`: `typedef enum logic [1:0] {WAIT_A, WAIT_B, WAIT_OP, RUN} loader_state_t`, plus the default `W` constant.
- Sub-module `key_debounce`: synchronizer, counter and `stable`. Parameter `DEBOUNCE_CYCLES`; ports `CLOCK_50`, `reset`, `key_n`, `press`.
- Top-level `operand_loader`: FSM and capture registers. `stage` is the enum cast to 2 bits.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`.
- **Full sequence.** Clean presses with `sw_data`=5, then 3, then `sw_op`=1 → `a`=5, `b`=3, `op`=1, `valid`=1. `start` high for exactly 1 cycle; `stage`=3.
- **Latency.** `key_n` goes low at edge 1 and is held → `stage` changes from 0 to 1 exactly at edge 8, and not before.
- **Bounce.** `key_n` low for 3 cycles, high for 1, then low and held → exactly one `press`; `stage` advances by 1 only. A 2-cycle low glitch alone → no change.
- **Switch isolation.** In RUN, toggle `sw_data` through 0–F and `sw_op` → `a`, `b` and `op` unchanged; `valid` stays 1.
- **Restart.** Press in RUN → `valid`=0 and `stage`=0 on the capture edge; `a`, `b` and `op` keep their old values until recaptured.
- **Async reset.** Assert `reset` between clock edges while in WAIT_OP with the key held → outputs are 0 immediately and `stage`=0. After release with the key still held, one `press` arrives 7 edges later and captures A.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and constants for the operand loader front end.
// Holds the capture-sequence state encoding and the default operand width.
// No ports; imported by operand_loader and key_debounce.
package loader_pkg;

    // Default operand width; the downstream add/sub unit is 2**2 = 4 bits wide.
    localparam int LOADER_W = 4;

    // Encoding doubles as the LED stage value, so the order is fixed.
    typedef enum logic [1:0] {
        WAIT_A  = 2'd0,
        WAIT_B  = 2'd1,
        WAIT_OP = 2'd2,
        RUN     = 2'd3
    } loader_state_t;

endpackage

// File: rtl/key_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, stability counter, press pulse.
// Ports: CLOCK_50/reset (async high), key_n raw active-low key, press 1-cycle pulse.
// Latency: press is high after edge DEBOUNCE_CYCLES+3, counting the first edge that samples key_n=0 as edge 1.
module key_debounce
    import loader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    logic             stable_prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q;

    // Counter clears whenever the synchronized level agrees with stable, so any
    // bounce shorter than DEBOUNCE_CYCLES cycles restarts the count.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            // Idle level is released (1): a key held through reset counts as a new press.
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            stable_q      <= 1'b1;
            stable_prev_q <= 1'b1;
            cnt_q         <= '0;
            press_q       <= 1'b0;
        end else begin
            sync1_q       <= key_n;
            sync2_q       <= sync1_q;
            stable_q      <= stable_d;
            cnt_q         <= cnt_d;
            stable_prev_q <= stable_q;
            // Falling edge of the debounced level only; release is ignored.
            press_q       <= stable_prev_q & ~stable_q;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/operand_loader.sv
// Three-press capture sequencer: A, then B, then add/sub select; holds them stable with valid.
// Ports: CLOCK_50/reset (async high), key_n, sw_data, sw_op in; a, b, op, valid, start, stage out.
// Switches are sampled only on the capture edge; between presses they never reach the outputs.
module operand_loader
    import loader_pkg::*;
#(
    parameter int W               = LOADER_W,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic         CLOCK_50,
    input  logic         reset,
    input  logic         key_n,
    input  logic [W-1:0] sw_data,
    input  logic         sw_op,
    output logic [W-1:0] a,
    output logic [W-1:0] b,
    output logic         op,
    output logic         valid,
    output logic         start,
    output logic [1:0]   stage
);

    logic press;

    loader_state_t state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic          op_q, op_d;
    logic          valid_q, valid_d;
    logic          start_q, start_d;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .key_n    (key_n),
        .press    (press)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        valid_d = valid_q;
        start_d = 1'b0;
        if (press) begin
            unique case (state_q)
                WAIT_A: begin
                    a_d     = sw_data;
                    state_d = WAIT_B;
                end
                WAIT_B: begin
                    b_d     = sw_data;
                    state_d = WAIT_OP;
                end
                WAIT_OP: begin
                    op_d    = sw_op;
                    valid_d = 1'b1;
                    start_d = 1'b1;
                    state_d = RUN;
                end
                RUN: begin
                    // Operands stay visible until recaptured; only valid drops.
                    valid_d = 1'b0;
                    state_d = WAIT_A;
                end
                default: state_d = WAIT_A;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= WAIT_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 1'b0;
            valid_q <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            valid_q <= valid_d;
            start_q <= start_d;
        end
    end

    assign a     = a_q;
    assign b     = b_q;
    assign op    = op_q;
    assign valid = valid_q;
    assign start = start_q;
    assign stage = 2'(state_q);

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader with DEBOUNCE_CYCLES=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
// Every comparison goes through check(); a single summary line ends the run.
module tb_operand_loader;

    localparam int W = 4;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         key_n = 1'b1;
    logic [W-1:0] sw_data = '0;
    logic         sw_op = 1'b0;
    logic [W-1:0] a, b;
    logic         op, valid, start;
    logic [1:0]   stage;

    int n_chk = 0;
    int n_bad = 0;
    int start_cnt = 0;

    operand_loader #(
        .W               (W),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .key_n    (key_n),
        .sw_data  (sw_data),
        .sw_op    (sw_op),
        .a        (a),
        .b        (b),
        .op       (op),
        .valid    (valid),
        .start    (start),
        .stage    (stage)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (start) start_cnt++;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Clean press: capture happens on edge D+4 = 8, then a long release.
    task automatic press_key();
        key_n = 1'b0;
        tick(12);
        key_n = 1'b1;
        tick(12);
    endtask

    initial begin
        int s0;
        tick(2);
        #1;
        // Reset state while reset is still asserted.
        check("rst_a", a, 0);
        check("rst_b", b, 0);
        check("rst_op", op, 0);
        check("rst_valid", valid, 0);
        check("rst_start", start, 0);
        check("rst_stage", stage, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick(2);

        // Latency on first press: edge 7 still WAIT_A, edge 8 captures A.
        sw_data = 4'd5;
        key_n = 1'b0;
        tick(7);
        check("lat_stage_e7", stage, 0);
        tick(1);
        check("lat_stage_e8", stage, 1);
        check("lat_a", a, 5);
        tick(4);
        key_n = 1'b1;
        tick(12);

        // Rest of the full sequence.
        sw_data = 4'd3;
        press_key();
        check("seq_b", b, 3);
        check("seq_stage_b", stage, 2);
        sw_op = 1'b1;
        s0 = start_cnt;
        press_key();
        check("seq_a", a, 5);
        check("seq_b2", b, 3);
        check("seq_op", op, 1);
        check("seq_valid", valid, 1);
        check("seq_stage", stage, 3);
        check("seq_start_pulses", start_cnt - s0, 1);
        check("seq_start_low", start, 0);

        // Switch isolation in RUN.
        for (int v = 0; v < 16; v++) begin
            sw_data = 4'(v);
            sw_op = v[0];
            tick(1);
        end
        check("iso_a", a, 5);
        check("iso_b", b, 3);
        check("iso_op", op, 1);
        check("iso_valid", valid, 1);
        check("iso_stage", stage, 3);

        // Restart from RUN: valid drops on edge 8, operands retained.
        sw_data = 4'hE;
        sw_op = 1'b0;
        key_n = 1'b0;
        tick(7);
        check("rs_valid_e7", valid, 1);
        tick(1);
        check("rs_valid", valid, 0);
        check("rs_stage", stage, 0);
        check("rs_a", a, 5);
        check("rs_b", b, 3);
        check("rs_op", op, 1);
        tick(4);
        key_n = 1'b1;
        tick(12);

        // Bounce: 3 low, 1 high, then held low -> exactly one press.
        sw_data = 4'd9;
        key_n = 1'b0;
        tick(3);
        key_n = 1'b1;
        tick(1);
        key_n = 1'b0;
        tick(20);
        key_n = 1'b1;
        tick(16);
        check("bnc_stage", stage, 1);
        check("bnc_a", a, 9);
        // 2-cycle glitch alone: nothing happens.
        sw_data = 4'd6;
        key_n = 1'b0;
        tick(2);
        key_n = 1'b1;
        tick(16);
        check("glitch_stage", stage, 1);
        check("glitch_b", b, 3);

        // Reach WAIT_OP, hold key, assert reset between edges.
        sw_data = 4'd7;
        press_key();
        check("ar_pre_stage", stage, 2);
        check("ar_pre_b", b, 7);
        key_n = 1'b0;
        tick(3);
        #2;
        reset = 1'b1;
        #1;
        check("ar_a", a, 0);
        check("ar_b", b, 0);
        check("ar_op", op, 0);
        check("ar_valid", valid, 0);
        check("ar_stage", stage, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        sw_data = 4'hC;
        // Key still held: press after edge 7, capture on edge 8.
        tick(7);
        check("ar_stage_e7", stage, 0);
        tick(1);
        check("ar_stage_e8", stage, 1);
        check("ar_cap_a", a, 12);
        check("ar_cap_b", b, 0);
        tick(20);
        check("held_one_press", stage, 1);
        key_n = 1'b1;
        tick(4);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
